// File: rtl/iir_mac_sequencer_if.sv
// Stream-in, stream-out and MAC request/result signals of the IIR MAC sequencer.
// master = sequencer side, slave = environment (source, sink and MAC unit).
interface iir_mac_sequencer_if #(
   parameter int WIDTH        = 32,
   parameter int FILTER_ORDER = 2
);
   localparam int TAPW = $clog2(2*FILTER_ORDER+1);

   logic [WIDTH-1:0]   s00_axis_input_tdata;
   logic               s00_axis_input_tvalid;
   logic               s00_axis_input_tlast;
   logic               s00_axis_input_tready;

   logic [WIDTH-1:0]   m00_axis_output_tdata;
   logic               m00_axis_output_tvalid;
   logic               m00_axis_output_tlast;
   logic [WIDTH/8-1:0] m00_axis_output_tstrb;
   logic               m00_axis_output_tready;

   logic               mac_valid;
   logic [TAPW-1:0]    mac_tap;
   logic [WIDTH-1:0]   mac_operand;
   logic               mac_sub;
   logic               mac_first;
   logic               mac_last;
   logic [WIDTH-1:0]   mac_result;
   logic               mac_result_valid;

   modport master (
      input  s00_axis_input_tdata, s00_axis_input_tvalid, s00_axis_input_tlast,
      output s00_axis_input_tready,
      output m00_axis_output_tdata, m00_axis_output_tvalid, m00_axis_output_tlast,
      output m00_axis_output_tstrb,
      input  m00_axis_output_tready,
      output mac_valid, mac_tap, mac_operand, mac_sub, mac_first, mac_last,
      input  mac_result, mac_result_valid
   );

   modport slave (
      output s00_axis_input_tdata, s00_axis_input_tvalid, s00_axis_input_tlast,
      input  s00_axis_input_tready,
      input  m00_axis_output_tdata, m00_axis_output_tvalid, m00_axis_output_tlast,
      input  m00_axis_output_tstrb,
      output m00_axis_output_tready,
      input  mac_valid, mac_tap, mac_operand, mac_sub, mac_first, mac_last,
      output mac_result, mac_result_valid
   );
endinterface

// File: rtl/iir_mac_sequencer.sv
// Direct-form-I IIR sequencer: one sample in flight, 2*FILTER_ORDER+1 MAC requests starting 1 cycle after accept,
// result held on m00 until tready (s00 stalled meanwhile). IIR_FLUSH_ON_TLAST_EN: zero histories after a tlast output.
module iir_mac_sequencer #(
   parameter int WIDTH           = 32,
   parameter int FILTER_ORDER    = 2,
   parameter int INTEGER_LENGTH  = 11,
   parameter int FRACTION_LENGTH = 20
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                hist_clr,
   iir_mac_sequencer_if.master bus
);
   localparam int TAPS = 2*FILTER_ORDER+1;
   localparam int TAPW = $clog2(TAPS);

   if (1 + INTEGER_LENGTH + FRACTION_LENGTH != WIDTH) begin : g_fmt_chk
      $error("sample format does not add up to WIDTH");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, OUT} state_e;

   state_e           state_q, state_d;
   logic [TAPW-1:0]  tap_q, tap_d;
   logic [WIDTH-1:0] x_cur_q, x_cur_d;
   logic             tlast_q, tlast_d;
   logic [WIDTH-1:0] out_dat_q, out_dat_d;
   logic             clr_pend_q, clr_pend_d;
   logic [WIDTH-1:0] x_hist_q [FILTER_ORDER];
   logic [WIDTH-1:0] x_hist_d [FILTER_ORDER];
   logic [WIDTH-1:0] y_hist_q [FILTER_ORDER];
   logic [WIDTH-1:0] y_hist_d [FILTER_ORDER];

   logic s_acc, out_fire, last_tap, flush_tlast;

   assign s_acc    = (state_q == IDLE) && bus.s00_axis_input_tvalid;
   assign out_fire = (state_q == OUT) && bus.m00_axis_output_tready;
   assign last_tap = (tap_q == TAPW'(TAPS-1));
`ifdef IIR_FLUSH_ON_TLAST_EN
   assign flush_tlast = tlast_q;
`else
   assign flush_tlast = 1'b0;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         tap_q      <= '0;
         x_cur_q    <= '0;
         tlast_q    <= 1'b0;
         out_dat_q  <= '0;
         clr_pend_q <= 1'b0;
         for (int i = 0; i < FILTER_ORDER; i++) begin
            x_hist_q[i] <= '0;
            y_hist_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         tap_q      <= tap_d;
         x_cur_q    <= x_cur_d;
         tlast_q    <= tlast_d;
         out_dat_q  <= out_dat_d;
         clr_pend_q <= clr_pend_d;
         x_hist_q   <= x_hist_d;
         y_hist_q   <= y_hist_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (s_acc)                state_d = ISSUE;
         ISSUE:    if (last_tap)             state_d = WAIT_RES;
         WAIT_RES: if (bus.mac_result_valid) state_d = OUT;
         OUT:      if (out_fire)             state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   always_comb begin
      tap_d      = tap_q;
      x_cur_d    = x_cur_q;
      tlast_d    = tlast_q;
      out_dat_d  = out_dat_q;
      clr_pend_d = clr_pend_q;
      x_hist_d   = x_hist_q;
      y_hist_d   = y_hist_q;

      // In IDLE the clear lands before any accepted sample reads history; otherwise it waits for OUT to exit.
      if (hist_clr && state_q == IDLE) begin
         for (int i = 0; i < FILTER_ORDER; i++) begin
            x_hist_d[i] = '0;
            y_hist_d[i] = '0;
         end
      end else if (hist_clr) begin
         clr_pend_d = 1'b1;
      end

      if (s_acc) begin
         x_cur_d = bus.s00_axis_input_tdata;
         tlast_d = bus.s00_axis_input_tlast;
         tap_d   = '0;
      end

      if (state_q == ISSUE && !last_tap) tap_d = tap_q + TAPW'(1);

      if (state_q == WAIT_RES && bus.mac_result_valid) begin
         out_dat_d = bus.mac_result;
         for (int i = FILTER_ORDER-1; i > 0; i--) begin
            x_hist_d[i] = x_hist_q[i-1];
            y_hist_d[i] = y_hist_q[i-1];
         end
         x_hist_d[0] = x_cur_q;
         y_hist_d[0] = bus.mac_result;
      end

      if (out_fire) begin
         clr_pend_d = 1'b0;
         if (clr_pend_q || hist_clr || flush_tlast) begin
            for (int i = 0; i < FILTER_ORDER; i++) begin
               x_hist_d[i] = '0;
               y_hist_d[i] = '0;
            end
         end
      end
   end

   always_comb begin
      bus.s00_axis_input_tready  = (state_q == IDLE);
      bus.m00_axis_output_tvalid = (state_q == OUT);
      bus.m00_axis_output_tlast  = (state_q == OUT) && tlast_q;
      bus.m00_axis_output_tstrb  = (state_q == OUT) ? '1 : '0;
      bus.m00_axis_output_tdata  = out_dat_q;
      bus.mac_valid   = 1'b0;
      bus.mac_tap     = '0;
      bus.mac_operand = '0;
      bus.mac_sub     = 1'b0;
      bus.mac_first   = 1'b0;
      bus.mac_last    = 1'b0;
      if (state_q == ISSUE) begin
         bus.mac_valid   = 1'b1;
         bus.mac_tap     = tap_q;
         bus.mac_first   = (tap_q == '0);
         bus.mac_last    = last_tap;
         bus.mac_operand = x_cur_q;
         for (int i = 0; i < FILTER_ORDER; i++) begin
            if (tap_q == TAPW'(i+1)) bus.mac_operand = x_hist_q[i];
            if (tap_q == TAPW'(i+FILTER_ORDER+1)) begin
               bus.mac_operand = y_hist_q[i];
               bus.mac_sub     = 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Bench for iir_mac_sequencer: directed and random samples against a history-queue reference model,
// with a MAC stand-in of programmable latency.
module tb_iir_mac_sequencer;
   localparam int W    = 32;
   localparam int FO   = 2;
   localparam int TAPS = 2*FO+1;
   localparam int TW   = $clog2(TAPS);

   logic clk;
   logic aresetn;
   logic hist_clr;
   int   checks;
   int   failures;

   logic [W-1:0] xh [$];
   logic [W-1:0] yh [$];

   iir_mac_sequencer_if #(.WIDTH(W), .FILTER_ORDER(FO)) bus ();

   iir_mac_sequencer #(
      .WIDTH(W), .FILTER_ORDER(FO), .INTEGER_LENGTH(11), .FRACTION_LENGTH(20)
   ) dut (
      .aclk(clk), .aresetn(aresetn), .hist_clr(hist_clr), .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_zero();
      foreach (xh[i]) xh[i] = '0;
      foreach (yh[i]) yh[i] = '0;
   endtask

   // One complete sample: accept, tap sequence, MAC result after lat cycles, bp cycles of output stall.
   task automatic do_sample(input logic [W-1:0] x, input logic last, input logic clr_acc,
                            input logic clr_wait, input int lat, input int bp,
                            input logic [W-1:0] res, input string tag);
      logic [W-1:0] exp_op [TAPS];
      logic [TW-1:0] k_tap;
      logic k_sub, k_first, k_last;
      checks++;
      if (bus.s00_axis_input_tready !== 1'b1 || bus.m00_axis_output_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL %s idle: s00_tready=%b m00_tvalid=%b want 1/0", tag,
                  bus.s00_axis_input_tready, bus.m00_axis_output_tvalid);
      end
      if (clr_acc) model_zero();
      exp_op[0] = x;
      for (int i = 0; i < FO; i++) begin
         exp_op[1+i]    = xh[i];
         exp_op[1+FO+i] = yh[i];
      end
      bus.s00_axis_input_tdata  = x;
      bus.s00_axis_input_tlast  = last;
      bus.s00_axis_input_tvalid = 1'b1;
      hist_clr = clr_acc;
      @(negedge clk);
      bus.s00_axis_input_tvalid = 1'b0;
      bus.s00_axis_input_tdata  = $urandom;
      bus.s00_axis_input_tlast  = 1'($urandom);
      hist_clr = 1'b0;
      for (int k = 0; k < TAPS; k++) begin
         k_tap = TW'(k);
         k_sub = (k > FO);
         k_first = (k == 0);
         k_last = (k == TAPS-1);
         checks++;
         if ({bus.mac_valid, bus.mac_tap, bus.mac_operand, bus.mac_sub, bus.mac_first,
              bus.mac_last, bus.s00_axis_input_tready} !==
             {1'b1, k_tap, exp_op[k], k_sub, k_first, k_last, 1'b0}) begin
            failures++;
            $display("FAIL %s tap%0d: vld=%b tap=%0d op=%h sub=%b first=%b last=%b rdy=%b want op=%h sub=%b",
                     tag, k, bus.mac_valid, bus.mac_tap, bus.mac_operand, bus.mac_sub,
                     bus.mac_first, bus.mac_last, bus.s00_axis_input_tready, exp_op[k], k_sub);
         end
         // A stray result strobe during ISSUE must be ignored.
         bus.mac_result_valid = (k == 1);
         bus.mac_result       = $urandom;
         @(negedge clk);
      end
      for (int i = 1; i < lat; i++) begin
         checks++;
         if ({bus.mac_valid, bus.s00_axis_input_tready, bus.m00_axis_output_tvalid} !== 3'b000) begin
            failures++;
            $display("FAIL %s wait: mac_valid=%b s00_tready=%b m00_tvalid=%b want 000", tag,
                     bus.mac_valid, bus.s00_axis_input_tready, bus.m00_axis_output_tvalid);
         end
         @(negedge clk);
      end
      bus.mac_result_valid = 1'b1;
      bus.mac_result       = res;
      hist_clr             = clr_wait;
      @(negedge clk);
      bus.mac_result_valid = 1'b0;
      bus.mac_result       = $urandom;
      hist_clr             = 1'b0;
      for (int i = 0; i <= bp; i++) begin
         checks++;
         if ({bus.m00_axis_output_tvalid, bus.m00_axis_output_tlast, bus.m00_axis_output_tstrb,
              bus.m00_axis_output_tdata, bus.s00_axis_input_tready, bus.mac_valid} !==
             {1'b1, last, 4'hF, res, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s out%0d: tvalid=%b tlast=%b tstrb=%h tdata=%h s00_tready=%b want 1/%b/f/%h/0",
                     tag, i, bus.m00_axis_output_tvalid, bus.m00_axis_output_tlast,
                     bus.m00_axis_output_tstrb, bus.m00_axis_output_tdata,
                     bus.s00_axis_input_tready, last, res);
         end
         if (i == bp) begin
            bus.m00_axis_output_tready = 1'b1;
            bus.mac_result_valid       = 1'b0;
         end else begin
            bus.m00_axis_output_tready = 1'b0;
            bus.mac_result_valid       = 1'($urandom);
            bus.mac_result             = $urandom;
         end
         @(negedge clk);
      end
      bus.m00_axis_output_tready = 1'b0;
      bus.mac_result_valid       = 1'b0;
      checks++;
      if ({bus.m00_axis_output_tvalid, bus.m00_axis_output_tstrb, bus.s00_axis_input_tready} !== 6'b0_0000_1) begin
         failures++;
         $display("FAIL %s release: tvalid=%b tstrb=%h s00_tready=%b want 0/0/1", tag,
                  bus.m00_axis_output_tvalid, bus.m00_axis_output_tstrb, bus.s00_axis_input_tready);
      end
      xh.push_front(x);   void'(xh.pop_back());
      yh.push_front(res); void'(yh.pop_back());
      if (clr_wait) model_zero();
`ifdef IIR_FLUSH_ON_TLAST_EN
      if (last) model_zero();
`endif
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      for (int c = 0; c < 5; c++) begin
         bus.s00_axis_input_tdata   = $urandom;
         bus.s00_axis_input_tvalid  = 1'($urandom);
         bus.s00_axis_input_tlast   = 1'($urandom);
         bus.m00_axis_output_tready = 1'($urandom);
         bus.mac_result             = $urandom;
         bus.mac_result_valid       = 1'($urandom);
         hist_clr                   = 1'($urandom);
         @(negedge clk);
         checks++;
         if ({bus.s00_axis_input_tready, bus.m00_axis_output_tvalid, bus.m00_axis_output_tlast,
              bus.m00_axis_output_tstrb, bus.m00_axis_output_tdata, bus.mac_valid, bus.mac_tap,
              bus.mac_operand, bus.mac_sub, bus.mac_first, bus.mac_last} !==
             {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset%0d: s00_tready=%b m00_tvalid=%b tstrb=%h tdata=%h mac_valid=%b want 1/0/0/0/0",
                     c, bus.s00_axis_input_tready, bus.m00_axis_output_tvalid,
                     bus.m00_axis_output_tstrb, bus.m00_axis_output_tdata, bus.mac_valid);
         end
      end
      bus.s00_axis_input_tvalid  = 1'b0;
      bus.s00_axis_input_tlast   = 1'b0;
      bus.m00_axis_output_tready = 1'b0;
      bus.mac_result_valid       = 1'b0;
      hist_clr                   = 1'b0;
      aresetn                    = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_first_and_history();
      do_sample(32'h0010_0000, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0008_0000, "first");
      do_sample(32'h0020_0000, 1'b0, 1'b0, 1'b0, 3, 0, 32'h0013_0000, "history");
   endtask

   task automatic test_backpressure();
      do_sample(32'h0030_0000, 1'b0, 1'b0, 1'b0, 2, 10, 32'h1234_5678, "bp_nolast");
      do_sample(32'hFFF0_0000, 1'b1, 1'b0, 1'b0, 1, 10, 32'h8765_4321, "bp_last");
   endtask

   task automatic test_hist_clr();
      do_sample(32'h0001_0000, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0002_0000, "pre_clr");
      do_sample(32'h0004_0000, 1'b0, 1'b1, 1'b0, 2, 1, 32'h0005_0000, "clr_accept");
      do_sample(32'h0006_0000, 1'b0, 1'b0, 1'b1, 3, 2, 32'h0007_0000, "clr_wait");
      do_sample(32'h0008_0000, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0009_0000, "after_clr");
      hist_clr = 1'b1;
      @(negedge clk);
      hist_clr = 1'b0;
      model_zero();
      do_sample(32'h000A_0000, 1'b0, 1'b0, 1'b0, 1, 0, 32'h000B_0000, "after_idle_clr");
   endtask

   task automatic test_flush();
      do_sample(32'h0011_0000, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0022_0000, "flush_fill");
      do_sample(32'h0033_0000, 1'b1, 1'b0, 1'b0, 2, 0, 32'h0044_0000, "flush_tlast");
      do_sample(32'h0010_0000, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0055_0000, "flush_next");
   endtask

   task automatic test_reset_mid_issue();
      bus.s00_axis_input_tdata  = 32'hDEAD_BEEF;
      bus.s00_axis_input_tlast  = 1'b1;
      bus.s00_axis_input_tvalid = 1'b1;
      @(negedge clk);
      bus.s00_axis_input_tvalid = 1'b0;
      @(negedge clk);
      #2 aresetn = 1'b0;
      #1;
      checks++;
      if ({bus.s00_axis_input_tready, bus.m00_axis_output_tvalid, bus.m00_axis_output_tstrb,
           bus.mac_valid} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid_issue: s00_tready=%b m00_tvalid=%b tstrb=%h mac_valid=%b want 1/0/0/0",
                  bus.s00_axis_input_tready, bus.m00_axis_output_tvalid,
                  bus.m00_axis_output_tstrb, bus.mac_valid);
      end
      @(negedge clk);
      aresetn = 1'b1;
      model_zero();
      @(negedge clk);
      do_sample(32'h0010_0000, 1'b0, 1'b0, 1'b0, 2, 0, 32'h0001_2345, "post_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         do_sample($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), $urandom_range(1, 4), $urandom_range(0, 3),
                   $urandom, "random");
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      hist_clr = 1'b0;
      aresetn  = 1'b0;
      for (int i = 0; i < FO; i++) begin
         xh.push_back('0);
         yh.push_back('0);
      end
      test_reset();
      test_first_and_history();
      test_backpressure();
      test_hist_clr();
      test_flush();
      test_reset_mid_issue();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
